serial_subtractor_32: RTL and testbench

Multi-cycle 32-bit subtractor computing `out = in1 - in2 - bin` one DIGIT_W-bit slice per clock, LSB slice first, with a borrow rippled between slices through a register. It is the inverse-operation companion to the team's 32-bit ripple-carry adder and serves area-constrained datapaths that can trade latency for a narrow slice adder. A valid/ready handshake sits on both the operand side and the result side.

---
 rtl/serial_subtractor_32.sv | 133 +++++++++++++
 tb/tb_serial_subtractor_32.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_32.sv
// Multi-cycle 32-bit subtractor: out = in1 - in2 - bin, one DIGIT_W-bit slice per clock, LSB first.
// Optional signed-overflow flag enabled by defining SERIAL_SUB_OVF_EN; otherwise ovf is tied to 0.
module serial_subtractor_32 #(
    parameter int unsigned DIGIT_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        bout,
    output logic        ovf
);

    localparam int unsigned N     = 32 / DIGIT_W;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned SUM_W = DIGIT_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic               c_q, c_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        out_q, out_d;
    logic               bout_q, bout_d;
    logic               last_c;
    logic [SUM_W-1:0]   slice_sum_c;
    int unsigned        base_c;

    // Next-state and datapath: slice adder computes in1 + ~in2 + carry, carry preset to ~bin
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        idx_d       = idx_q;
        out_d       = out_q;
        bout_d      = bout_q;
        base_c      = 32'(idx_q) * DIGIT_W;
        slice_sum_c = {1'b0, a_q[base_c +: DIGIT_W]} + {1'b0, ~b_q[base_c +: DIGIT_W]}
                      + SUM_W'(c_q);
        last_c      = (state_q == RUN) && (idx_q == LAST_IDX);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in1;
                    b_d     = in2;
                    c_d     = ~bin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_d[base_c +: DIGIT_W] = slice_sum_c[DIGIT_W-1:0];
                c_d   = slice_sum_c[DIGIT_W];
                idx_d = idx_q + IDX_W'(1);
                if (last_c) begin
                    bout_d  = ~slice_sum_c[DIGIT_W];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            out_q   <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: operand signs differ and result sign differs from the minuend
    always_comb begin
        ovf_d = ovf_q;
        if (last_c) begin
            ovf_d = (a_q[31] ^ b_q[31]) & (out_d[31] ^ a_q[31]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign bout      = bout_q;

endmodule

// File: tb/tb_serial_subtractor_32.sv
// Directed bench for serial_subtractor_32 with DIGIT_W = 8, 1 and 32 instances.
module tb_serial_subtractor_32;

`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        bin;
    logic        iv   [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov   [3];
    logic [31:0] res  [3];
    logic        bo   [3];
    logic        of   [3];

    int n_checks;
    int n_errors;

    serial_subtractor_32 #(.DIGIT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in1(in1), .in2(in2), .bin(bin), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out(res[0]), .bout(bo[0]), .ovf(of[0])
    );

    serial_subtractor_32 #(.DIGIT_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in1(in1), .in2(in2), .bin(bin), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out(res[1]), .bout(bo[1]), .ovf(of[1])
    );

    serial_subtractor_32 #(.DIGIT_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in1(in1), .in2(in2), .bin(bin), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out(res[2]), .bout(bo[2]), .ovf(of[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for out_valid after acceptance; in_ready must stay low while running
    task automatic wait_done(input int s, input string tag, output int lat);
        lat = 0;
        while (!ov[s] && lat < 200) begin
            if (irdy[s] !== 1'b0) check({tag, "_run_rdy"}, 32'(irdy[s]), 32'd0);
            @(negedge clk);
            lat++;
        end
        if (!ov[s]) check({tag, "_timeout"}, 32'(ov[s]), 32'd1);
    endtask

    task automatic complete(input int s, input string tag);
        ordy[s] = 1'b1;
        @(negedge clk);
        ordy[s] = 1'b0;
        check({tag, "_ov_fall"}, 32'(ov[s]), 32'd0);
        check({tag, "_rdy_rise"}, 32'(irdy[s]), 32'd1);
    endtask

    task automatic do_op(input int s, input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic bi, input logic [31:0] exp_out, input logic exp_bout,
                         input logic exp_ovf, input int exp_lat);
        int lat;
        @(negedge clk);
        in1 = a; in2 = b; bin = bi; iv[s] = 1'b1;
        check({tag, "_in_rdy"}, 32'(irdy[s]), 32'd1);
        @(negedge clk);
        iv[s] = 1'b0;
        in1 = ~a; in2 = ~b; bin = ~bi;
        wait_done(s, tag, lat);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_out"}, res[s], exp_out);
        check({tag, "_bout"}, 32'(bo[s]), 32'(exp_bout));
        check({tag, "_ovf"}, 32'(of[s]), 32'(exp_ovf & OVF_EN));
        check({tag, "_done_rdy"}, 32'(irdy[s]), 32'd0);
        complete(s, tag);
    endtask

    initial begin
        int lat;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        in1 = '0; in2 = '0; bin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ordy[i] = 1'b0;
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_in_rdy", 32'(irdy[0]), 32'd0);
        check("rst_ov", 32'(ov[0]), 32'd0);
        check("rst_out", res[0], 32'd0);
        check("rst_bout", 32'(bo[0]), 32'd0);
        check("rst_ovf", 32'(of[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_rdy", 32'(irdy[0]), 32'd1);

        // DIGIT_W=8 directed vectors
        do_op(0, "w8_5m3", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 4);
        do_op(0, "w8_0m1", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4);
        do_op(0, "w8_bin", 32'h0000_0010, 32'h0000_000F, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 4);
        do_op(0, "w8_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 4);
        do_op(0, "w8_ovf2", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1, 4);

        // Backpressure: result held, new operands ignored until handshake completes
        @(negedge clk);
        in1 = 32'h0000_0100; in2 = 32'h0000_0001; bin = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        wait_done(0, "bp_first", lat);
        check("bp_first_out", res[0], 32'h0000_00FF);
        in1 = 32'hAAAA_AAAA; in2 = 32'h5555_5555; bin = 1'b0; iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_ov", 32'(ov[0]), 32'd1);
            check("bp_hold_out", res[0], 32'h0000_00FF);
            check("bp_hold_rdy", 32'(irdy[0]), 32'd0);
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;
        check("bp_idle_rdy", 32'(irdy[0]), 32'd1);
        check("bp_idle_ov", 32'(ov[0]), 32'd0);
        @(negedge clk);
        iv[0] = 1'b0;
        check("bp_accept_rdy", 32'(irdy[0]), 32'd0);
        wait_done(0, "bp_second", lat);
        check("bp_second_lat", 32'(lat), 32'd4);
        check("bp_second_out", res[0], 32'h5555_5555);
        check("bp_second_bout", 32'(bo[0]), 32'd0);
        check("bp_second_ovf", 32'(of[0]), 32'(OVF_EN));
        complete(0, "bp_second");

        // Reset at the second RUN edge discards the partial result
        @(negedge clk);
        in1 = 32'hFFFF_FFFF; in2 = 32'h0000_0001; bin = 1'b0; iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_out", res[0], 32'd0);
        check("mid_rst_ov", 32'(ov[0]), 32'd0);
        check("mid_rst_bout", 32'(bo[0]), 32'd0);
        check("mid_rst_ovf", 32'(of[0]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_idle", 32'(irdy[0]), 32'd1);
        check("mid_rst_ov2", 32'(ov[0]), 32'd0);
        do_op(0, "w8_after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h0123_4567, 1'b0, 1'b0, 4);

        // Other slice widths
        do_op(1, "w1_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 32);
        do_op(1, "w1_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 32);
        do_op(2, "w32_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1);
        do_op(2, "w32_mix", 32'h1234_5678, 32'h1111_1111, 1'b1, 32'h0123_4566, 1'b0, 1'b0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
